dataselect_skid: RTL

- Parametrised N-way, W-bit data selector with a registered 2-entry skid buffer and a valid/ready handshake on both sides.
- Successor to the fixed 5-bit 2:1 combinational selector.
- Used in the multicycle datapath for register-destination, ALU-operand and write-back source selection, where the selected value must be held stable across control-FSM stalls.
- Out-of-range selects are flagged alongside the data.

---
 rtl/dataselect_skid.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dataselect_skid.sv
// N-way, W-bit data selector feeding a registered 2-entry skid buffer.
// Both sides use a valid/ready handshake, and out-of-range selects travel with the data as sel_err.
module dataselect_skid #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  localparam logic [1:0]       ST_EMPTY = 2'd0;
  localparam logic [1:0]       ST_ONE   = 2'd1;
  localparam logic [1:0]       ST_FULL  = 2'd2;
  localparam int               SEL_N    = 2 ** SEL_W;
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);

  logic [1:0]       state_r;
  logic [1:0]       state_n_s;
  logic [WIDTH-1:0] head_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             head_err_r;
  logic             skid_err_r;
  logic [WIDTH-1:0] new_data_s;
  logic             new_err_s;
  logic             push_s;
  logic             pop_s;
  logic             head_new_s;
  logic             head_skid_s;
  logic             skid_new_s;
  logic [WIDTH-1:0] cand_s [SEL_N];

  // Pad the candidate table to the full sel range; unused codes fall back to input 0.
  for (genvar k = 0; k < SEL_N; k++) begin : g_cand
    if (k < NUM_IN) begin : g_in
      assign cand_s[k] = data_in[k*WIDTH +: WIDTH];
    end else begin : g_dflt
      assign cand_s[k] = data_in[WIDTH-1:0];
    end
  end

  assign new_data_s = cand_s[sel];
  assign new_err_s  = ({1'b0, sel} >= NUM_IN_L);

  assign in_ready  = (state_r != ST_FULL);
  assign out_valid = (state_r != ST_EMPTY);
  assign occupancy = state_r;
  assign data_out  = head_data_r;
  assign sel_err   = head_err_r;

  assign push_s = in_valid & in_ready;
  assign pop_s  = out_valid & out_ready;

  // Next-state and register-load decisions; flush overrides everything and freezes the data registers.
  always_comb begin
    state_n_s   = state_r;
    head_new_s  = 1'b0;
    head_skid_s = 1'b0;
    skid_new_s  = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_n_s  = ST_ONE;
          head_new_s = 1'b1;
        end else begin
          state_n_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          state_n_s  = ST_ONE;
          head_new_s = 1'b1;
        end else if (push_s) begin
          state_n_s  = ST_FULL;
          skid_new_s = 1'b1;
        end else if (pop_s) begin
          state_n_s = ST_EMPTY;
        end else begin
          state_n_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_n_s   = ST_ONE;
          head_skid_s = 1'b1;
        end else begin
          state_n_s = ST_FULL;
        end
      end
      default: begin
        state_n_s = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_n_s   = ST_EMPTY;
      head_new_s  = 1'b0;
      head_skid_s = 1'b0;
      skid_new_s  = 1'b0;
    end else begin
      state_n_s = state_n_s;
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      head_data_r <= '0;
      head_err_r  <= 1'b0;
      skid_data_r <= '0;
      skid_err_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (head_new_s) begin
        head_data_r <= new_data_s;
        head_err_r  <= new_err_s;
      end else if (head_skid_s) begin
        head_data_r <= skid_data_r;
        head_err_r  <= skid_err_r;
      end
      if (skid_new_s) begin
        skid_data_r <= new_data_s;
        skid_err_r  <= new_err_s;
      end
    end
  end

endmodule
